// File: rtl/score_display.sv
// Binary score to BCD, scanned onto a 4-digit active-low seven-segment display.
// Leading tens digit is blanked; the display flashes while the win score is shown.
module score_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000,
  parameter int WIN_SCORE   = 32
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [5:0] score_count,
  output logic [6:0] SEGS,
  output logic [3:0] AN,
  output logic       DP,
  output logic       win
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [5:0]    score_q;
  logic [5:0]    cur_q, cur_d;
  logic [13:0]   sh_q, sh_d, adj;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          win_q, win_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    dig_q, dig_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    segs_q, segs_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      score_q <= '0;
      cur_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      win_q   <= 1'b0;
      ref_q   <= '0;
      dig_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b1;
      an_q    <= 4'hF;
      segs_q  <= 7'h7F;
    end else begin
      state_q <= state_d;
      score_q <= score_count;
      cur_q   <= cur_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      win_q   <= win_d;
      ref_q   <= ref_d;
      dig_q   <= dig_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      segs_q  <= segs_d;
    end
  end

  // Shift-add-3; digits are only committed on the last shift.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    win_d   = win_q;
    adj     = sh_q;
    if (adj[9:6] >= 4'd5)
      adj[9:6] = adj[9:6] + 4'd3;
    if (adj[13:10] >= 4'd5)
      adj[13:10] = adj[13:10] + 4'd3;
    case (state_q)
      IDLE: begin
        if (score_q != cur_q) begin
          sh_d    = {8'b0, score_q};
          cur_d   = score_q;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = {adj[12:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          tens_d  = sh_d[13:10];
          ones_d  = sh_d[9:6];
          win_d   = (32'(cur_q) == WIN_SCORE);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ref_d = ref_q + RW'(1);
    dig_d = dig_q;
    if (ref_q == REF_MAX) begin
      ref_d = '0;
      dig_d = dig_q + 2'd1;
    end
  end

  // Blink restarts in the visible phase whenever win rises or falls.
  always_comb begin
    blk_d   = blk_q + BW'(1);
    phase_d = phase_q;
    if (!win_d || !win_q) begin
      blk_d   = '0;
      phase_d = 1'b1;
    end else if (blk_q == BLK_MAX) begin
      blk_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    an_d   = 4'hF;
    segs_d = 7'h7F;
    unique case (1'b1)
      (dig_q == 2'd0): begin
        an_d   = 4'b1110;
        segs_d = seg7(ones_q);
      end
      (dig_q == 2'd1 && tens_q != 4'd0): begin
        an_d   = 4'b1101;
        segs_d = seg7(tens_q);
      end
      default: ;
    endcase
    if (win_q && !phase_q)
      an_d = 4'hF;
  end

  assign SEGS = segs_q;
  assign AN   = an_q;
  assign DP   = 1'b1;
  assign win  = win_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: converted digits go through a scoreboard,
// the display is checked each cycle against a time-based scan/blink model.
module tb_score_display;

  localparam int RD = 4;
  localparam int BD = 8;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] o;
    logic       w;
  } exp_t;

  logic       CLK = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] score_count = '0;
  logic [6:0] SEGS;
  logic [3:0] AN;
  logic       DP;
  logic       win;

  exp_t sb[$];
  exp_t prev;
  exp_t mon;
  int   total = 0;
  int   passed = 0;
  int   edges = 0;
  int   win_edge = -1;

  score_display #(
    .REFRESH_DIV(RD),
    .BLINK_DIV(BD),
    .WIN_SCORE(32)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .score_count(score_count),
    .SEGS(SEGS),
    .AN(AN),
    .DP(DP),
    .win(win)
  );

  initial begin
    wait (clk_en);
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK or negedge reset)
    if (!reset) edges <= 0;
    else edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Every change of the committed digits must be the next expected result.
  always @(negedge CLK) begin
    if (!reset) begin
      prev = '0;
    end else begin
      mon = {dut.tens_q, dut.ones_q, win};
      if (mon !== prev) begin
        if (sb.size() == 0) begin
          total++;
          $error("FAIL sb_extra: got %0h want nothing", mon);
        end else begin
          chk("sb_pair", 32'(mon), 32'(sb.pop_front()));
        end
        prev = mon;
      end
    end
  end

  function automatic logic [6:0] code(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int s);
    exp_t e;
    e.t = 4'(s / 10);
    e.o = 4'(s % 10);
    e.w = (s == 32);
    sb.push_back(e);
  endtask

  // Outputs after edge e reflect scan/blink state after edge e-1.
  task automatic check_disp(input string tag, input int t, input int o);
    int   k;
    int   slot;
    bit   won;
    bit   ph;
    logic [3:0] ea;
    logic [6:0] es;
    k    = edges - 1;
    slot = (k / RD) % 4;
    won  = (win_edge >= 0) && (k >= win_edge);
    ph   = won ? (((k - win_edge) / BD) % 2 == 0) : 1'b1;
    ea   = 4'hF;
    es   = 7'h7F;
    if (slot == 0) begin
      ea = 4'b1110;
      es = code(o);
    end else if (slot == 1 && t != 0) begin
      ea = 4'b1101;
      es = code(t);
    end
    if (won && !ph) ea = 4'hF;
    chk({tag, "_an"}, 32'(AN), 32'(ea));
    if (ea != 4'hF || slot >= 2)
      chk({tag, "_segs"}, 32'(SEGS), 32'(es));
    chk({tag, "_dp"}, 32'(DP), 32'd1);
  endtask

  initial begin
    score_count = 6'($urandom_range(0, 63));
    #2 reset = 1'b0;
    #1;
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_segs", 32'(SEGS), 32'h7F);
    chk("rst_dp", 32'(DP), 32'd1);
    chk("rst_win", 32'(win), 32'd0);

    score_count = 6'd0;
    clk_en = 1'b1;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b1;
    repeat (16) begin
      tick();
      check_disp("zero", 0, 0);
    end

    score_count = 6'd17;
    push(17);
    tick();
    repeat (6) tick();
    chk("lat_before", 32'({dut.tens_q, dut.ones_q}), 32'h00);
    tick();
    chk("lat_exact", 32'({dut.tens_q, dut.ones_q}), 32'h17);
    repeat (16) begin
      tick();
      check_disp("s17", 1, 7);
    end

    score_count = 6'd23;
    push(23);
    tick();
    tick();
    score_count = 6'd31;
    push(31);
    repeat (16) tick();
    repeat (16) begin
      tick();
      check_disp("s31", 3, 1);
    end

    score_count = 6'd32;
    push(32);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (win) break;
    end
    chk("win_rise", 32'(win), 32'd1);
    win_edge = edges;
    repeat (40) begin
      tick();
      check_disp("blink", 3, 2);
    end

    score_count = 6'd0;
    push(0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!win) break;
    end
    chk("win_fall", 32'(win), 32'd0);
    win_edge = -1;
    repeat (16) begin
      tick();
      check_disp("unwin", 0, 0);
    end

    score_count = 6'd63;
    push(63);
    repeat (10) tick();
    chk("s63_digits", 32'({dut.tens_q, dut.ones_q}), 32'h63);
    chk("s63_win", 32'(win), 32'd0);
    repeat (16) begin
      tick();
      check_disp("s63", 6, 3);
    end

    score_count = 6'd5;
    push(5);
    repeat (10) tick();
    repeat (16) begin
      tick();
      check_disp("s05", 0, 5);
    end

    score_count = 6'd45;
    tick();
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_an", 32'(AN), 32'hF);
    chk("mid_segs", 32'(SEGS), 32'h7F);
    chk("mid_dp", 32'(DP), 32'd1);
    chk("mid_win", 32'(win), 32'd0);
    chk("mid_digits", 32'({dut.tens_q, dut.ones_q}), 32'h00);
    #2 reset = 1'b1;
    push(45);
    for (int i = 0; i < 8; i++) begin
      tick();
      if ({dut.tens_q, dut.ones_q} == 8'h45) break;
    end
    chk("reconv", 32'({dut.tens_q, dut.ones_q}), 32'h45);
    repeat (16) begin
      tick();
      check_disp("s45", 4, 5);
    end

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
